// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: 800x600@60 defaults, a timing record and
// helpers deriving line/frame totals and sync window bounds.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FP     = 40;
    localparam int unsigned DEF_H_SYNC   = 128;
    localparam int unsigned DEF_H_BP     = 88;
    localparam int unsigned DEF_V_ACTIVE = 600;
    localparam int unsigned DEF_V_FP     = 1;
    localparam int unsigned DEF_V_SYNC   = 4;
    localparam int unsigned DEF_V_BP     = 23;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
    } vga_timing_t;

    localparam vga_timing_t DEF_TIMING = '{
        h_active: 16'(DEF_H_ACTIVE), h_fp: 16'(DEF_H_FP),
        h_sync:   16'(DEF_H_SYNC),   h_bp: 16'(DEF_H_BP),
        v_active: 16'(DEF_V_ACTIVE), v_fp: 16'(DEF_V_FP),
        v_sync:   16'(DEF_V_SYNC),   v_bp: 16'(DEF_V_BP)
    };

    function automatic int unsigned axis_total(input int unsigned active, fp, sync, bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned axis_sync_start(input int unsigned active, fp);
        return active + fp;
    endfunction

    // Inclusive: last count at which sync is still active.
    function automatic int unsigned axis_sync_stop(input int unsigned active, fp, sync);
        return active + fp + sync - 1;
    endfunction

    function automatic int unsigned h_total(input vga_timing_t t);
        return axis_total(32'(t.h_active), 32'(t.h_fp), 32'(t.h_sync), 32'(t.h_bp));
    endfunction

    function automatic int unsigned v_total(input vga_timing_t t);
        return axis_total(32'(t.v_active), 32'(t.v_fp), 32'(t.v_sync), 32'(t.v_bp));
    endfunction

    function automatic int unsigned hs_start(input vga_timing_t t);
        return axis_sync_start(32'(t.h_active), 32'(t.h_fp));
    endfunction

    function automatic int unsigned hs_stop(input vga_timing_t t);
        return axis_sync_stop(32'(t.h_active), 32'(t.h_fp), 32'(t.h_sync));
    endfunction

    function automatic int unsigned vs_start(input vga_timing_t t);
        return axis_sync_start(32'(t.v_active), 32'(t.v_fp));
    endfunction

    function automatic int unsigned vs_stop(input vga_timing_t t);
        return axis_sync_stop(32'(t.v_active), 32'(t.v_fp), 32'(t.v_sync));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with registered blank/sync decoded
// from the next count (zero relative latency); holds everything while step=0.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = 800,
    parameter int unsigned FP     = 40,
    parameter int unsigned SYNC   = 128,
    parameter int unsigned BP     = 88,
    parameter logic        POL    = 1'b1,
    parameter int unsigned W      = 11
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         blank,
    output logic         sync,
    output logic         wrap
);

    localparam logic [W-1:0] LAST        = W'(axis_total(ACTIVE, FP, SYNC, BP) - 1);
    localparam logic [W-1:0] BLANK_START = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START  = W'(axis_sync_start(ACTIVE, FP));
    localparam logic [W-1:0] SYNC_STOP   = W'(axis_sync_stop(ACTIVE, FP, SYNC));

    logic [W-1:0] count_d, count_q;
    logic         blank_d, blank_q;
    logic         sync_d,  sync_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (step) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
        // Decoding the next count keeps blank/sync aligned with the count shown.
        blank_d = (count_d >= BLANK_START);
        sync_d  = ((count_d >= SYNC_START) && (count_d <= SYNC_STOP)) ? POL : ~POL;
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
        blank_q <= blank_d;
        sync_q  <= sync_d;
    end

    assign count = count_q;
    assign blank = blank_q;
    assign sync  = sync_q;
    assign wrap  = (count_q == LAST);

endmodule

// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator: counters, sync/blank, line/frame strobes and
// frame counter, all registered; advances only when en=1, otherwise holds (strobes clear).
module vga_timing_param
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned FRAME_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               hblnk,
    output logic               vblnk,
    output logic [11:0]        rgb,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam vga_timing_t TIMING = '{
        h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
        v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP)
    };

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_param
        $error("vga_timing_param: every active, porch and sync count must be non-zero");
    end
    if (64'(h_total(TIMING)) > (64'd1 << CNT_W) ||
        64'(v_total(TIMING)) > (64'd1 << CNT_W)) begin : g_cnt_too_narrow
        $error("vga_timing_param: CNT_W too small for the line or frame total");
    end

    logic               h_wrap, v_wrap, v_step;
    logic               line_start_d, line_start_q;
    logic               frame_start_d, frame_start_q;
    logic [FRAME_W-1:0] frame_cnt_d, frame_cnt_q;

    assign v_step = h_wrap & en;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(CNT_W)
    ) u_h_axis (
        .clk(clk), .clear(rst), .step(en),
        .count(hcount), .blank(hblnk), .sync(hsync), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(CNT_W)
    ) u_v_axis (
        .clk(clk), .clear(rst), .step(v_step),
        .count(vcount), .blank(vblnk), .sync(vsync), .wrap(v_wrap)
    );

    always_comb begin
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        if (rst) begin
            frame_cnt_d = '0;
        end else if (v_step) begin
            line_start_d = 1'b1;
            if (v_wrap) begin
                frame_start_d = 1'b1;
                frame_cnt_d   = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        line_start_q  <= line_start_d;
        frame_start_q <= frame_start_d;
        frame_cnt_q   <= frame_cnt_d;
    end

    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
    assign rgb         = '0;

endmodule
